// File: rtl/l2_line_responder_if.sv
// ============================================================================
// Module   : l2_line_responder_if
// Purpose  : L1-side line request bus plus word-wide backing-memory bus.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface l2_line_responder_if;
  logic         L2_read;
  logic         L2_write;
  logic [15:0]  L2_address;
  logic [127:0] L2_wdata;
  logic [127:0] L2_rdata;
  logic         L2_resp;
  logic [15:0]  pmem_address;
  logic [15:0]  pmem_wdata;
  logic [15:0]  pmem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic         pmem_resp;

  // Responder view: serves L1 line requests, drives the word memory.
  modport slave (
    input  L2_read, L2_write, L2_address, L2_wdata, pmem_rdata, pmem_resp,
    output L2_rdata, L2_resp, pmem_address, pmem_wdata, pmem_read, pmem_write
  );

  // Environment view: the L1 requester together with the backing memory.
  modport master (
    output L2_read, L2_write, L2_address, L2_wdata, pmem_rdata, pmem_resp,
    input  L2_rdata, L2_resp, pmem_address, pmem_wdata, pmem_read, pmem_write
  );
endinterface

`default_nettype wire

// File: rtl/l2_line_responder.sv
// ============================================================================
// Module   : l2_line_responder
// Purpose  : Splits 128-bit line reads/writebacks into eight 16-bit memory beats.
// Revision : 1.0
// ============================================================================
`default_nettype none

module l2_line_responder (
  input  logic              clk,
  input  logic              reset,
  l2_line_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_BEAT  = 2'd1,
    WRITE_BEAT = 2'd2,
    RESPOND    = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_next_state;
  logic [2:0]   r_beat;
  logic [15:0]  r_base;
  logic [127:0] r_wbuf;
  logic [127:0] r_rdata;
  logic [6:0]   w_word_lsb;

  assign w_word_lsb = {r_beat, 4'h0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.L2_resp      = 1'b0;
    bus.pmem_address = r_base + {12'd0, r_beat, 1'b0};
    bus.pmem_wdata   = r_wbuf[w_word_lsb +: 16];
    case (r_state)
      IDLE: begin
        // A simultaneous read+write request is treated as a writeback.
        if (bus.L2_write) begin
          w_next_state = WRITE_BEAT;
        end else if (bus.L2_read) begin
          w_next_state = READ_BEAT;
        end
      end
      READ_BEAT: begin
        bus.pmem_read = 1'b1;
        if (bus.pmem_resp && (r_beat == 3'd7)) begin
          w_next_state = RESPOND;
        end
      end
      WRITE_BEAT: begin
        bus.pmem_write = 1'b1;
        if (bus.pmem_resp && (r_beat == 3'd7)) begin
          w_next_state = RESPOND;
        end
      end
      RESPOND: begin
        bus.L2_resp  = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_beat  <= 3'd0;
      r_base  <= 16'd0;
      r_wbuf  <= 128'd0;
      r_rdata <= 128'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.L2_write || bus.L2_read) begin
            r_base <= {bus.L2_address[15:4], 4'h0};
            r_beat <= 3'd0;
          end
          if (bus.L2_write) begin
            r_wbuf <= bus.L2_wdata;
          end
        end
        READ_BEAT: begin
          if (bus.pmem_resp) begin
            r_rdata[w_word_lsb +: 16] <= bus.pmem_rdata;
            if (r_beat != 3'd7) begin
              r_beat <= r_beat + 3'd1;
            end
          end
        end
        WRITE_BEAT: begin
          if (bus.pmem_resp && (r_beat != 3'd7)) begin
            r_beat <= r_beat + 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.L2_rdata = r_rdata;

endmodule

`default_nettype wire
